bigreg_sequencer: RTL and testbench
===================================

Name: bigreg_sequencer

Overview:
- Owns the RTL-side read port of the AXI mem_map and serves the three PS_BIGREG groups: seed, chan_mux and sdc.
- When the PS sets a group's valid entry, the block reads the group's 16-bit entries in order and clears their fresh bits. It then presents the assembled wide register to the single downstream consumer over valid/ready.
- Round-robin arbitration decides which group is served when more than one is pending.

Parameters:
- MEM_SIZE, 256, mem_map depth; address width AW = $clog2(MEM_SIZE) = 8.
- DATA_W, 16, width of one mem_map entry (WD_DATA_WIDTH).
- OUT_W, 256, width of the assembled register (BATCH_WIDTH = SDC_DATA_WIDTH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- valid_fresh  in  3  fresh bits of PS_SEED_VALID_ID (bit 0), CHAN_MUX_VALID_ID (bit 1), SDC_VALID_ID (bit 2).
- rd_en  out  1  mem_map read strobe.
- rd_addr  out  AW  mem_map read index.
- rd_data  in  DATA_W  mem_map read data, valid exactly 1 cycle after rd_en.
- clr_en  out  1  fresh-bit clear strobe.
- clr_addr  out  AW  index whose fresh bit is cleared.
- out_data  out  OUT_W  assembled register.
- out_sel  out  2  group being presented: 0 seed, 1 chan_mux, 2 sdc.
- out_valid  out  1  out_data and out_sel are valid.
- out_ready  in  1  consumer accepts the presented register.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Group table (all values from the package):
  - seed: base 1, N=16, valid 17.
  - chan_mux: base 30, N=2, valid 32.
  - sdc: base 33, N=16, valid 49.
- Reset state: FSM in IDLE. rd_en, clr_en, out_valid and busy = 0. rd_addr, clr_addr, out_data and out_sel = 0. last_grant = 2, so seed has top priority after reset.
- rst_n assertion mid-operation aborts immediately to the reset state. Fresh bits not yet cleared stay set, and the group is re-served after reset.
- IDLE:
  - If valid_fresh != 0, grant the first pending group scanning from (last_grant+1) mod 3 and wrap.
  - Latch grp, set last_grant = grp, clear the assembly register, k = 0, go to READ.
- READ, N cycles:
  - Each cycle drive rd_en=1, rd_addr=base+k, clr_en=1, clr_addr=base+k; then k++.
  - rd_data arriving for entry k is written to assembly bits [16k+15:16k], one cycle after its read.
  - After the cycle with k=N-1, go to DRAIN.
- DRAIN, 1 cycle:
  - Capture the last entry.
  - Drive clr_en=1, clr_addr=valid_id; rd_en=0.
  - Go to PRESENT.
- PRESENT:
  - out_valid=1, out_data=assembly, out_sel=grp.
  - Hold all three stable until out_ready=1 is sampled with out_valid=1. That is the transfer cycle; go to IDLE, and out_valid=0 on the next cycle.
  - If out_ready is already high on entry, the transfer completes in 1 cycle.
- chan_mux presents zero-extended: bits [31:0] carry the data, [255:32] are 0.
- Latency: with grant in IDLE at cycle G, reads occupy G+1..G+N and DRAIN is G+N+1. out_valid rises at G+N+2, which is G+18 for seed/sdc and G+4 for chan_mux.
- Back-to-back: after a transfer there is at least 1 IDLE cycle before the next READ.
- valid_fresh is sampled only in IDLE. A PS rewrite of an already-cleared entry during READ sets its fresh bit again; that group is re-served later with the new contents. No data is merged across grants.
- Simultaneous clear and PS write to the same fresh bit: the mem_map gives priority to the PS set.
- rd_addr and clr_addr hold their last value when the corresponding strobe is low.

Decomposition:
- mem_layout_pkg gains:
  - typedef enum {GRP_SEED, GRP_CHAN, GRP_SDC} bigreg_grp_t;
  - localparam arrays GRP_BASE, GRP_LEN and GRP_VALID, derived from the existing ID macros.
- One sub-module, rr_arb3: a 3-requester round-robin arbiter with registered last_grant, a combinational one-hot grant and a grant_idx output.

Test Plan:
- Pending chan_mux only: mem_map[30]=16'hBEEF, mem_map[31]=16'h1234, valid_fresh=3'b010, out_ready=1.
  -> out_data=256'h1234_BEEF, out_sel=1, out_valid rises at G+4.
  -> clr_addr sequence is 30, 31, 32.
- Seed: entries 1..16 = 16'h0001..16'h0010.
  -> out_data[15:0]=1 and out_data[255:240]=16'h0010.
  -> 16 reads at consecutive addresses, then clr of 17; out_valid at G+18.
- All three pending from reset.
  -> Service order seed, chan_mux, sdc.
  -> Re-raising seed during the sdc service gives order seed, chan_mux, sdc, seed.
- Backpressure: out_ready held 0 for 10 cycles in PRESENT.
  -> out_valid, out_data and out_sel stable; no rd_en or clr_en; transfer on the first ready cycle.
- rst_n asserted at the 8th READ cycle of sdc.
  -> All outputs 0 asynchronously.
  -> After release, with valid_fresh[2] still 1, sdc is re-read from base 33.
- PS rewrites entry 33 during the sdc READ at k=5.
  -> The current output carries the old value.
  -> After the PS re-sets valid 49, the second service carries the new value.

Source files
------------

// File: rtl/mem_layout_pkg.sv
// mem_layout_pkg: layout of the PS_BIGREG region of the AXI mem_map.
// Holds the mem_map geometry, the index of every PS_BIGREG entry, the group
// table that bigreg_sequencer walks, and the sequencer state encoding.
// No ports (package).
package mem_layout_pkg;

   localparam int MEM_SIZE = 256;
   localparam int AW       = $clog2(MEM_SIZE);
   localparam int DATA_W   = 16;
   localparam int OUT_W    = 256;
   localparam int NUM_GRP  = 3;

   // Entry indices of each PS_BIGREG group: first data entry and valid entry.
   localparam logic [AW-1:0] PS_SEED_BASE_ID   = 8'd1;
   localparam logic [AW-1:0] PS_SEED_VALID_ID  = 8'd17;
   localparam logic [AW-1:0] CHAN_MUX_BASE_ID  = 8'd30;
   localparam logic [AW-1:0] CHAN_MUX_VALID_ID = 8'd32;
   localparam logic [AW-1:0] SDC_BASE_ID       = 8'd33;
   localparam logic [AW-1:0] SDC_VALID_ID      = 8'd49;

   typedef enum logic [1:0] {
      GRP_SEED = 2'd0,
      GRP_CHAN = 2'd1,
      GRP_SDC  = 2'd2
   } bigreg_grp_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READ    = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_PRESENT = 2'd3
   } bigreg_state_t;

   // Group table, element 0 = seed, 1 = chan_mux, 2 = sdc.
   // Each group's data entries sit directly below its valid entry.
   localparam logic [NUM_GRP-1:0][AW-1:0] GRP_BASE =
      {SDC_BASE_ID, CHAN_MUX_BASE_ID, PS_SEED_BASE_ID};
   localparam logic [NUM_GRP-1:0][AW-1:0] GRP_VALID =
      {SDC_VALID_ID, CHAN_MUX_VALID_ID, PS_SEED_VALID_ID};
   localparam logic [NUM_GRP-1:0][4:0] GRP_LEN =
      {5'(SDC_VALID_ID - SDC_BASE_ID),
       5'(CHAN_MUX_VALID_ID - CHAN_MUX_BASE_ID),
       5'(PS_SEED_VALID_ID - PS_SEED_BASE_ID)};

   // Table lookups with constant indices; the unused encoding maps to seed.
   function automatic logic [AW-1:0] grp_base(input bigreg_grp_t g);
      case (g)
         GRP_SEED: return GRP_BASE[0];
         GRP_CHAN: return GRP_BASE[1];
         GRP_SDC:  return GRP_BASE[2];
         default:  return GRP_BASE[0];
      endcase
   endfunction

   function automatic logic [AW-1:0] grp_valid(input bigreg_grp_t g);
      case (g)
         GRP_SEED: return GRP_VALID[0];
         GRP_CHAN: return GRP_VALID[1];
         GRP_SDC:  return GRP_VALID[2];
         default:  return GRP_VALID[0];
      endcase
   endfunction

   // Index of the last data entry of a group (N-1).
   function automatic logic [3:0] grp_last_idx(input bigreg_grp_t g);
      logic [4:0] len_s;
      case (g)
         GRP_SEED: len_s = GRP_LEN[0];
         GRP_CHAN: len_s = GRP_LEN[1];
         GRP_SDC:  len_s = GRP_LEN[2];
         default:  len_s = GRP_LEN[0];
      endcase
      return 4'(len_s - 5'd1);
   endfunction

endpackage

// File: rtl/rr_arb3.sv
// rr_arb3: three-requester round-robin arbiter.
// The search starts at the requester after the last granted one and wraps.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req[2:0]    request vector
//   update      the current grant is taken; remember it as last grant
//   gnt[2:0]    combinational one-hot grant (all zero when no request)
//   gnt_idx     index of the granted requester
module rr_arb3 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic       update,
   output logic [2:0] gnt,
   output logic [1:0] gnt_idx
);

   logic [1:0] last_grant_r;

   // Pick the first requester after last_grant_r, wrapping around.
   always_comb begin
      gnt_idx = 2'd0;
      case (last_grant_r)
         2'd0: begin
            if (req[1])      gnt_idx = 2'd1;
            else if (req[2]) gnt_idx = 2'd2;
            else             gnt_idx = 2'd0;
         end
         2'd1: begin
            if (req[2])      gnt_idx = 2'd2;
            else if (req[0]) gnt_idx = 2'd0;
            else             gnt_idx = 2'd1;
         end
         default: begin
            if (req[0])      gnt_idx = 2'd0;
            else if (req[1]) gnt_idx = 2'd1;
            else             gnt_idx = 2'd2;
         end
      endcase
      if (|req) gnt = 3'b001 << gnt_idx;
      else      gnt = 3'b000;
   end

   // Last-grant register; reset value 2 gives requester 0 first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                last_grant_r <= 2'd2;
      else if (update && (|req)) last_grant_r <= gnt_idx;
      else                       last_grant_r <= last_grant_r;
   end

endmodule

// File: rtl/bigreg_sequencer.sv
// bigreg_sequencer: serves the PS_BIGREG groups (seed, chan_mux, sdc).
// When a group's valid entry is fresh, the block reads the group's 16-bit
// entries in order (clearing each fresh bit as it goes), clears the valid
// entry, and presents the assembled 256-bit register over valid/ready.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   valid_fresh[2:0]     fresh bits of the seed/chan_mux/sdc valid entries
//   rd_en, rd_addr       mem_map read strobe and index
//   rd_data              mem_map read data, one cycle after rd_en
//   clr_en, clr_addr     fresh-bit clear strobe and index
//   out_data, out_sel    assembled register and its group
//   out_valid, out_ready presentation handshake
//   busy                 sequencer is not idle
module bigreg_sequencer
   import mem_layout_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        valid_fresh,
   output logic              rd_en,
   output logic [AW-1:0]     rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              clr_en,
   output logic [AW-1:0]     clr_addr,
   output logic [OUT_W-1:0]  out_data,
   output logic [1:0]        out_sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   bigreg_state_t     state_r, state_s;
   bigreg_grp_t       grp_r, grp_s;
   logic [3:0]        k_r, k_s, k_inc_s;
   logic              rd_en_r, rd_en_s;
   logic [AW-1:0]     rd_addr_r, rd_addr_s;
   logic              clr_en_r, clr_en_s;
   logic [AW-1:0]     clr_addr_r, clr_addr_s;
   logic              out_valid_r, out_valid_s;
   logic [1:0]        out_sel_r, out_sel_s;
   logic              busy_r;
   logic              cap_v_r;
   logic [3:0]        cap_idx_r;
   logic [OUT_W-1:0]  asm_r;
   logic              asm_clr_s;
   logic              arb_upd_s;
   logic [2:0]        gnt_s;
   logic [1:0]        gnt_idx_s;

   rr_arb3 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (valid_fresh),
      .update  (arb_upd_s),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s)
   );

   assign k_inc_s = k_r + 4'd1;

   // Next state plus the next value of every registered output, so the
   // strobes for a cycle are already set up on the edge that enters it.
   always_comb begin
      state_s     = state_r;
      grp_s       = grp_r;
      k_s         = k_r;
      rd_en_s     = 1'b0;
      rd_addr_s   = rd_addr_r;
      clr_en_s    = 1'b0;
      clr_addr_s  = clr_addr_r;
      out_valid_s = out_valid_r;
      out_sel_s   = out_sel_r;
      asm_clr_s   = 1'b0;
      arb_upd_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (|gnt_s) begin
               grp_s      = bigreg_grp_t'(gnt_idx_s);
               arb_upd_s  = 1'b1;
               asm_clr_s  = 1'b1;
               k_s        = 4'd0;
               rd_en_s    = 1'b1;
               rd_addr_s  = grp_base(bigreg_grp_t'(gnt_idx_s));
               clr_en_s   = 1'b1;
               clr_addr_s = grp_base(bigreg_grp_t'(gnt_idx_s));
               state_s    = ST_READ;
            end else begin
               state_s    = ST_IDLE;
            end
         end
         ST_READ: begin
            if (k_r == grp_last_idx(grp_r)) begin
               // Last data entry is on the bus; DRAIN clears the valid entry.
               clr_en_s   = 1'b1;
               clr_addr_s = grp_valid(grp_r);
               state_s    = ST_DRAIN;
            end else begin
               k_s        = k_inc_s;
               rd_en_s    = 1'b1;
               rd_addr_s  = grp_base(grp_r) + {4'd0, k_inc_s};
               clr_en_s   = 1'b1;
               clr_addr_s = grp_base(grp_r) + {4'd0, k_inc_s};
               state_s    = ST_READ;
            end
         end
         ST_DRAIN: begin
            out_valid_s = 1'b1;
            out_sel_s   = grp_r;
            state_s     = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (out_ready) begin
               out_valid_s = 1'b0;
               state_s     = ST_IDLE;
            end else begin
               state_s     = ST_PRESENT;
            end
         end
         default: begin
            out_valid_s = 1'b0;
            state_s     = ST_IDLE;
         end
      endcase
   end

   // FSM state, control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         grp_r       <= GRP_SEED;
         k_r         <= 4'd0;
         rd_en_r     <= 1'b0;
         rd_addr_r   <= 8'd0;
         clr_en_r    <= 1'b0;
         clr_addr_r  <= 8'd0;
         out_valid_r <= 1'b0;
         out_sel_r   <= 2'd0;
         busy_r      <= 1'b0;
         cap_v_r     <= 1'b0;
         cap_idx_r   <= 4'd0;
      end else begin
         state_r     <= state_s;
         grp_r       <= grp_s;
         k_r         <= k_s;
         rd_en_r     <= rd_en_s;
         rd_addr_r   <= rd_addr_s;
         clr_en_r    <= clr_en_s;
         clr_addr_r  <= clr_addr_s;
         out_valid_r <= out_valid_s;
         out_sel_r   <= out_sel_s;
         busy_r      <= (state_s != ST_IDLE);
         // rd_data for the read issued this cycle arrives next cycle.
         cap_v_r     <= rd_en_r;
         cap_idx_r   <= k_r;
      end
   end

   // Assembly register: cleared on grant, one 16-bit lane per returned read.
   // Lanes above the group's length stay zero, which zero-extends chan_mux.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         asm_r <= '0;
      else if (asm_clr_s) asm_r <= '0;
      else if (cap_v_r)   asm_r[{cap_idx_r, 4'b0000} +: DATA_W] <= rd_data;
      else                asm_r <= asm_r;
   end

   assign rd_en     = rd_en_r;
   assign rd_addr   = rd_addr_r;
   assign clr_en    = clr_en_r;
   assign clr_addr  = clr_addr_r;
   assign out_data  = asm_r;
   assign out_sel   = out_sel_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_bigreg_sequencer.sv
// tb_bigreg_sequencer: self-checking bench for bigreg_sequencer.
// Contains a mem_map model (data, fresh bits, one-cycle read, PS writes with
// priority over clears) and a reference model that predicts the served group
// by round-robin over the pending set and the presented data as the group's
// entries at grant time.
module tb_bigreg_sequencer;

   localparam int TB_BASE [3] = '{1, 30, 33};
   localparam int TB_LEN  [3] = '{16, 2, 16};
   localparam int TB_VID  [3] = '{17, 32, 49};

   logic         clk;
   logic         rst_n;
   logic [2:0]   valid_fresh;
   logic         rd_en;
   logic [7:0]   rd_addr;
   logic [15:0]  rd_data;
   logic         clr_en;
   logic [7:0]   clr_addr;
   logic [255:0] out_data;
   logic [1:0]   out_sel;
   logic         out_valid;
   logic         out_ready;
   logic         busy;

   logic         env_init;
   logic         ps_we;
   logic [7:0]   ps_addr;
   logic [15:0]  ps_data;
   logic [2:0]   ps_vset;
   logic [15:0]  mem [256];
   logic [255:0] fresh;

   int n_tests    = 0;
   int n_fail     = 0;
   int model_last = 2;
   int served [$];

   bigreg_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_fresh (valid_fresh),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .clr_en      (clr_en),
      .clr_addr    (clr_addr),
      .out_data    (out_data),
      .out_sel     (out_sel),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // mem_map model: registered read, fresh clears, PS writes win over clears.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (env_init) begin
         fresh <= '0;
      end else begin
         if (clr_en) fresh[clr_addr] <= 1'b0;
         if (ps_we) begin
            mem[ps_addr]   <= ps_data;
            fresh[ps_addr] <= 1'b1;
         end
         if (ps_vset[0]) fresh[17] <= 1'b1;
         if (ps_vset[1]) fresh[32] <= 1'b1;
         if (ps_vset[2]) fresh[49] <= 1'b1;
      end
   end

   assign valid_fresh = {fresh[49], fresh[32], fresh[17]};

   task automatic check(input string tag, input logic [299:0] got, input logic [299:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic ps_write(input logic [7:0] a, input logic [15:0] d);
      ps_we   = 1'b1;
      ps_addr = a;
      ps_data = d;
      @(negedge clk);
      ps_we   = 1'b0;
   endtask

   task automatic set_valids(input logic [2:0] m);
      ps_vset = m;
      @(negedge clk);
      ps_vset = 3'b000;
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {rd_en, rd_addr, clr_en, clr_addr, out_valid, out_sel, busy}, '0);
      check({tag, "_data"}, out_data, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      model_last = 2;
      @(negedge clk);
   endtask

   // One service, called at a negedge. hold = cycles of out_ready low in
   // PRESENT; rw_k = read index at which a PS write (rw_a, rw_d) is issued;
   // rst_k = read index at which rst_n is pulsed (service is abandoned).
   task automatic service(input int hold, input int rw_k, input logic [7:0] rw_a,
                          input logic [15:0] rw_d, input int rst_k);
      bit           found;
      int           g;
      int           n;
      logic [2:0]   pend;
      logic [7:0]   base;
      logic [7:0]   a;
      logic [7:0]   vid;
      logic [255:0] exp;
      found = 1'b0;
      for (int w = 0; w < 40; w++) begin
         if (!busy && valid_fresh != 3'b000) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("grant_wait", {299'd0, found}, {299'd0, 1'b1});
      if (!found) return;
      pend = valid_fresh;
      g = -1;
      for (int i = 1; i <= 3; i++) begin
         if (g < 0 && pend[(model_last + i) % 3]) g = (model_last + i) % 3;
      end
      model_last = g;
      served.push_back(g);
      n    = TB_LEN[g];
      base = 8'(TB_BASE[g]);
      vid  = 8'(TB_VID[g]);
      exp  = '0;
      for (int j = 0; j < n; j++) exp[16*j +: 16] = mem[8'(TB_BASE[g] + j)];
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         ps_we = 1'b0;
         if (k == rst_k) begin
            #1 rst_n = 1'b0;
            #1 check_all_zero("async_rst");
            @(negedge clk);
            check_all_zero("rst_hold");
            rst_n = 1'b1;
            model_last = 2;
            return;
         end
         a = base + 8'(k);
         check("read", {rd_en, rd_addr, clr_en, clr_addr, out_valid, busy},
               {1'b1, a, 1'b1, a, 1'b0, 1'b1});
         if (k == rw_k) begin
            ps_we   = 1'b1;
            ps_addr = rw_a;
            ps_data = rw_d;
         end
      end
      @(negedge clk);
      ps_we = 1'b0;
      a = base + 8'(n - 1);
      check("drain", {rd_en, rd_addr, clr_en, clr_addr, out_valid, busy},
            {1'b0, a, 1'b1, vid, 1'b0, 1'b1});
      out_ready = (hold == 0);
      @(negedge clk);
      check("present", {out_valid, out_sel, rd_en, clr_en}, {1'b1, 2'(g), 1'b0, 1'b0});
      check("present_data", out_data, exp);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold", {out_valid, out_sel, rd_en, clr_en, rd_addr, clr_addr, busy},
               {1'b1, 2'(g), 1'b0, 1'b0, a, vid, 1'b1});
         check("hold_data", out_data, exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("after_xfer", {out_valid, busy, rd_en}, 3'b000);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [2:0]  m;
      logic [15:0] old_v;
      clk       = 1'b0;
      rst_n     = 1'b0;
      env_init  = 1'b1;
      ps_we     = 1'b0;
      ps_addr   = 8'd0;
      ps_data   = 16'd0;
      ps_vset   = 3'b000;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      env_init = 1'b0;
      check_all_zero("por");
      rst_n = 1'b1;
      @(negedge clk);

      // chan_mux alone, consumer ready
      ps_write(8'd30, 16'hBEEF);
      ps_write(8'd31, 16'h1234);
      set_valids(3'b010);
      service(0, -1, 8'd0, 16'd0, -1);
      check("chan_data", out_data, 256'h1234_BEEF);
      check("chan_sel", {298'd0, out_sel}, 300'd1);

      // seed with entries 1..16
      for (int i = 0; i < 16; i++) ps_write(8'(1 + i), 16'(i + 1));
      set_valids(3'b001);
      service(0, -1, 8'd0, 16'd0, -1);
      check("seed_lo", {284'd0, out_data[15:0]}, 300'h0001);
      check("seed_hi", {284'd0, out_data[255:240]}, 300'h0010);

      // all three pending from reset; seed re-raised during sdc
      for (int i = 0; i < 16; i++) ps_write(8'(33 + i), 16'($urandom));
      do_reset();
      served.delete();
      set_valids(3'b111);
      service(0, -1, 8'd0, 16'd0, -1);
      service(0, -1, 8'd0, 16'd0, -1);
      service(0, 3, 8'd17, 16'h0001, -1);
      service(0, -1, 8'd0, 16'd0, -1);
      check("order_len", 300'(served.size()), 300'd4);
      if (served.size() == 4)
         check("order", {292'd0, 2'(served[0]), 2'(served[1]), 2'(served[2]), 2'(served[3])},
               {292'd0, 2'd0, 2'd1, 2'd2, 2'd0});

      // backpressure
      ps_write(8'd30, 16'($urandom));
      ps_write(8'd31, 16'($urandom));
      set_valids(3'b010);
      service(10, -1, 8'd0, 16'd0, -1);

      // reset at the 8th sdc read, then re-service from base 33
      set_valids(3'b100);
      service(0, -1, 8'd0, 16'd0, 7);
      check("fresh_kept", {297'd0, valid_fresh}, 300'b100);
      service(0, -1, 8'd0, 16'd0, -1);

      // PS rewrite of entry 33 while sdc is at k=5
      ps_write(8'd33, 16'h0BAD);
      old_v = 16'h0BAD;
      set_valids(3'b100);
      service(0, 5, 8'd33, 16'hCAFE, -1);
      check("rw_old", {284'd0, out_data[15:0]}, {284'd0, old_v});
      set_valids(3'b100);
      service(0, -1, 8'd0, 16'd0, -1);
      check("rw_new", {284'd0, out_data[15:0]}, 300'hCAFE);

      // randomized rounds
      for (int r = 0; r < 6; r++) begin
         m = 3'($urandom_range(7, 1));
         for (int gi = 0; gi < 3; gi++) begin
            if (m[gi]) begin
               for (int j = 0; j < TB_LEN[gi]; j++) ps_write(8'(TB_BASE[gi] + j), 16'($urandom));
            end
         end
         set_valids(m);
         for (int c = 0; c < 3; c++) begin
            if (m[c]) service($urandom_range(3, 0), -1, 8'd0, 16'd0, -1);
         end
         check("rand_drained", {297'd0, valid_fresh}, 300'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
